// File: rtl/ic_l2_refill.sv
// ic_l2_refill: I-cache line refill engine; fetches a 4x32 line critical-word-first
// over the shared memory port, then pulses l2_rdy and w_complete.
module ic_l2_refill #(
    parameter bit CWF    = 1'b1,
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [27:0]       l2_addr,
    input  logic              dc_req,
    output logic              ic_en,
    output logic              l2_rdy,
    output logic [127:0]      data_wd_l2,
    output logic              w_complete,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, FILL, DONE, COMMIT} state_t;
    state_t       r_state, w_next;
    logic [25:0]  r_line;
    logic [1:0]   r_start, r_cnt;
    logic [127:0] r_data;
    logic [1:0]   w_word;
    logic         w_accept, w_beat;
    assign w_word     = r_start + r_cnt;
    assign w_accept   = r_state == IDLE && irq && !dc_req;
    assign w_beat     = r_state == FILL && mem_ack;
    assign data_wd_l2 = r_data;
    always_comb begin
        w_next     = r_state;
        ic_en      = r_state != IDLE;
        mem_req    = r_state == FILL;
        l2_rdy     = r_state == DONE;
        w_complete = r_state == COMMIT;
        mem_addr   = mem_req ? ADDR_W'({r_line, w_word}) : '0;
        unique case (r_state)
            IDLE:    w_next = w_accept ? FILL : IDLE;
            FILL:    w_next = (w_beat && r_cnt == 2'd3) ? DONE : FILL;
            DONE:    w_next = COMMIT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_start <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_line  <= l2_addr[27:2];
                r_start <= CWF ? l2_addr[1:0] : 2'd0;
                r_cnt   <= '0;
            end
            // the 2-bit counter wraps back to 0 on the last beat
            if (w_beat) begin
                r_data[{w_word, 5'd0} +: 32] <= mem_rdata;
                r_cnt                        <= r_cnt + 2'd1;
            end
        end
    end
endmodule
